// File: rtl/hu_rr_arbiter.sv
// Round-robin arbiter with hold-until-release ownership and a registered one-hot grant.
// The grant moves straight to the next winner on release, so ownership hands over with no idle cycle.
//
// state | meaning
// IDLE  | no owner, grant zero; arbitrate over req every edge
// OWNED | one grant bit set; hold until done or owner's req drops
module hu_rr_arbiter #(
    parameter int width  = 4,
    parameter int iwidth = (width > 1) ? $clog2(width) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [width-1:0]  req,
    input  logic              done,
    output logic [width-1:0]  grant,
    output logic [iwidth-1:0] grant_idx,
    output logic              busy
);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t            state;
    logic [iwidth-1:0] ptr;
    logic [width-1:0]  cand;
    logic [width-1:0]  win_oh;
    logic              found;
    logic              release_own;
    int                win;
    int                best;
    logic [iwidth-1:0] win_idx;
    logic [iwidth-1:0] ptr_nxt;

    // Winner is the candidate at the smallest circular distance from ptr.
    // The owner's own request is masked while it is being released.
    always_comb begin
        cand = req;
        if (state == OWNED) cand = req & ~grant;
        found = 1'b0;
        win   = 0;
        best  = width;
        for (int i = 0; i < width; i++) begin
            int d;
            d = i - int'(ptr);
            if (d < 0) d = d + width;
            if (cand[i] && d < best) begin
                found = 1'b1;
                win   = i;
                best  = d;
            end
        end
        win_oh = '0;
        for (int i = 0; i < width; i++) win_oh[i] = (i == win);
        win_idx = iwidth'(win);
        ptr_nxt = (win >= width - 1) ? '0 : iwidth'(win + 1);
    end

    assign release_own = done || ((req & grant) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            ptr       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= OWNED;
                        grant     <= win_oh;
                        grant_idx <= win_idx;
                        busy      <= 1'b1;
                        ptr       <= ptr_nxt;
                    end
                end
                OWNED: begin
                    if (release_own) begin
                        if (found) begin
                            grant     <= win_oh;
                            grant_idx <= win_idx;
                            busy      <= 1'b1;
                            ptr       <= ptr_nxt;
                        end else begin
                            state     <= IDLE;
                            grant     <= '0;
                            grant_idx <= '0;
                            busy      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    grant     <= '0;
                    grant_idx <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hu_rr_arbiter.sv
// Scoreboard bench for hu_rr_arbiter at width 4 and width 1 against an ownership-level model.
module tb_hu_rr_arbiter;

    typedef struct {
        logic [3:0] g;
        int         idx;
        logic       busy;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req4;
    logic       done4;
    logic [3:0] grant4;
    logic [1:0] idx4;
    logic       busy4;
    logic [0:0] req1;
    logic       done1;
    logic [0:0] grant1;
    logic [0:0] idx1;
    logic       busy1;

    int checks = 0;
    int passes = 0;

    exp_t q4[$];
    exp_t q1[$];

    int own4 = -1, ptr4 = 0;
    int own1 = -1, ptr1 = 0;

    hu_rr_arbiter #(.width(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .done(done4),
        .grant(grant4), .grant_idx(idx4), .busy(busy4)
    );

    hu_rr_arbiter #(.width(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .done(done1),
        .grant(grant1), .grant_idx(idx1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    endtask

    // Ownership model: the owner keeps the grant until done or its request drops;
    // then the first requester (owner excluded) from ptr onward, wrapping, takes over.
    task automatic model_step(input int w, input logic [3:0] r, input logic d,
                              inout int own, inout int p);
        logic [3:0] c;
        int i;
        if (own >= 0 && !d && r[own]) return;
        c = r;
        if (own >= 0) c[own] = 1'b0;
        own = -1;
        for (int k = 0; k < w; k++) begin
            i = (p + k) % w;
            if (own < 0 && c[i]) own = i;
        end
        if (own >= 0) p = (own + 1) % w;
    endtask

    function automatic exp_t mk(input int own);
        exp_t e;
        e.g    = (own >= 0) ? (4'b0001 << own) : 4'b0000;
        e.idx  = (own >= 0) ? own : 0;
        e.busy = (own >= 0);
        return e;
    endfunction

    task automatic drive(input logic [3:0] r4, input logic d4, input logic r1, input logic d1);
        req4 = r4; done4 = d4; req1[0] = r1; done1 = d1;
        model_step(4, r4, d4, own4, ptr4);
        model_step(1, {3'b000, r1}, d1, own1, ptr1);
        q4.push_back(mk(own4));
        q1.push_back(mk(own1));
    endtask

    task automatic step(input logic [3:0] r4, input logic d4, input logic r1, input logic d1);
        @(negedge clk);
        drive(r4, d4, r1, d1);
    endtask

    // Monitor: compares whatever the DUT presents after each edge against the queued response.
    always @(posedge clk) begin
        #1;
        if (q4.size() > 0) begin
            exp_t e;
            e = q4.pop_front();
            chk("w4_grant", int'(grant4), int'(e.g));
            chk("w4_idx", int'(idx4), e.idx);
            chk("w4_busy", int'(busy4), int'(e.busy));
        end
        if (q1.size() > 0) begin
            exp_t e;
            e = q1.pop_front();
            chk("w1_grant", int'(grant1), int'(e.g[0]));
            chk("w1_busy", int'(busy1), int'(e.busy));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("w4_onehot0", int'($onehot0(grant4)), 1);
            chk("w4_busy_vs_grant", int'(busy4), int'(grant4 != 4'b0000));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req4 = '0; done4 = 1'b0; req1 = '0; done1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_grant4", int'(grant4), 0);
        chk("reset_idx4", int'(idx4), 0);
        chk("reset_busy4", int'(busy4), 0);
        chk("reset_grant1", int'(grant1), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two-requester handover, then release to idle
        step(4'b1010, 1'b0, 1'b1, 1'b0);
        step(4'b1010, 1'b1, 1'b1, 1'b1);
        step(4'b1010, 1'b1, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0, 1'b1);

        // All requesting, done every cycle: full rotation
        for (int k = 0; k < 8; k++) step(4'b1111, 1'b1, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 1'b0);

        // Owner 2 holds while req[0] toggles, then drops with req[0] high
        step(4'b0100, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) step({1'b0, 1'b1, 1'b0, k[0]}, 1'b0, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-ownership, then fresh arbitration from ptr 0
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_grant4", int'(grant4), 0);
        chk("async_rst_busy4", int'(busy4), 0);
        own4 = -1; ptr4 = 0; own1 = -1; ptr1 = 0;
        #1 rst_n = 1'b1;
        drive(4'b1000, 1'b0, 1'b0, 1'b0);
        step(4'b1001, 1'b1, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);

        // Width-1 hold across done: 1, 0, 1
        step(4'b0000, 1'b0, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0, 1'b0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            logic [3:0] r;
            r = 4'($urandom);
            step(r, ($urandom_range(0, 3) == 0), 1'($urandom), ($urandom_range(0, 2) == 0));
        end
        step(4'b0000, 1'b0, 1'b0, 1'b0);

        @(posedge clk);
        #2;
        chk("queue4_drained", q4.size(), 0);
        chk("queue1_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hu_rr_arbiter.md
HU_RR_ARBITER -- requirements
Module: hu_rr_arbiter

Interface
REQ-001 Parameter width, default 4: number of requesters; the block SHALL support any width >= 1.
REQ-002 Parameter iwidth, default $clog2(width) with a minimum of 1: width of the grant index.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 req  input  width  per-requester request level; bit i high means requester i wants ownership.
REQ-006 done  input  1  single-cycle pulse from the current owner: transaction complete, release the grant.
REQ-007 grant  output  width  registered one-hot grant vector, or all-zero; it directly drives the sel input of the downstream one-hot selector.
REQ-008 grant_idx  output  iwidth  binary index of the granted bit; 0 when grant is zero.
REQ-009 busy  output  1  high exactly when grant is non-zero.

Function
REQ-010 The block SHALL contain two states: IDLE (no owner) and OWNED (exactly one grant bit set).
REQ-011 grant SHALL be zero or one-hot in every cycle; more than one set bit SHALL never occur.
REQ-012 A priority pointer ptr (0..width-1) SHALL select the first candidate; the winner SHALL be the first requester with its req bit set, searching ptr, ptr+1, ... and wrapping modulo width.
REQ-013 IDLE with req != 0 at an edge: the block SHALL set grant to the winner's one-hot, enter OWNED and set ptr to winner+1 mod width; grant latency from the req rise SHALL be 1 cycle.
REQ-014 IDLE with req == 0: the block SHALL stay in IDLE with grant zero.
REQ-015 OWNED SHALL hold grant unchanged while req[owner] stays high and done is low; arrivals from other requesters SHALL NOT pre-empt the owner.
REQ-016 OWNED is released at an edge when done is high or req[owner] is low.
REQ-017 On release, the block SHALL arbitrate among the requesters other than the owner, with req[owner] masked for that cycle.
REQ-018 On release with a winner, the block SHALL move grant directly to that winner, with no idle cycle, stay in OWNED and update ptr per REQ-013.
REQ-019 On release with no winner, the block SHALL clear grant and enter IDLE.
REQ-020 done while in IDLE SHALL be ignored.
REQ-021 done and the owner's req drop in the same cycle SHALL be treated as a single release.
REQ-022 With width == 1, a requester that holds req high across a done SHALL see grant drop for one cycle (IDLE), then be re-granted.
REQ-023 Fairness: with all req held high and done pulsed every cycle, the grant SHALL rotate 0,1,...,width-1,0,...; no requester SHALL wait more than width-1 grants.
REQ-024 grant_idx and busy SHALL be registered alongside grant and change in the same cycle as grant.
REQ-025 req bits that are not the owner's SHALL be sampled only in the arbitration cycle; a pulse that falls entirely within an OWNED period with no release SHALL be lost.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, grant = 0, grant_idx = 0, busy = 0 and ptr = 0, regardless of clk.
REQ-027 Reset asserted mid-OWNED SHALL drop grant asynchronously, with no done required.
REQ-028 After rst_n deasserts, the first arbitration SHALL start at ptr = 0.

Verification
REQ-029 width=4; after reset, req=4'b1010 at edge 1 -> grant=4'b0010, grant_idx=1 and busy=1 after edge 1; ptr=2.
REQ-030 From REQ-029's state, hold req=4'b1010 and pulse done -> grant=4'b1000 on the next edge with no zero cycle; pulse done again -> grant=4'b0010.
REQ-031 width=4; req=4'b1111 held and done pulsed every cycle for 8 cycles -> grant sequence 0001,0010,0100,1000,0001,0010,0100,1000.
REQ-032 Owner 2 holds with done low for 10 cycles while req[0] toggles -> grant stays 4'b0100 throughout; dropping req[2] with req[0] high -> grant=4'b0001 on the next edge.
REQ-033 Assert rst_n low between edges while busy=1 -> grant=0 and busy=0 before the next edge; after release with req=4'b1000 -> grant=4'b1000 one cycle later.
REQ-034 width=1; req held high and done pulsed -> grant sequence 1,0,1; a one-hot/zero assertion on grant SHALL hold in every scenario.
